muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers, for MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO in the MIPS processor core. It sits beside the ALU. It accepts an operation from the controller, computes over multiple cycles while asserting `busy_out`, and the processor stalls PC advance while `busy_out` is high. Result width, and therefore latency, is set by `W`.

---
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Divider datapath is compiled only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start_in,
  input  logic [1:0]   op_in,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         hi_we_in,
  input  logic         lo_we_in,
  input  logic [W-1:0] wdata_in,
  output logic         busy_out,
  output logic         done_out,
  output logic [W-1:0] hi_out,
  output logic [W-1:0] lo_out
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t         state;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic           is_signed;
  logic           neg_res;
  logic [2*W-1:0] prod;
  logic [CW-1:0]  count;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;
  logic           busy_q;
  logic           done_q;

  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   fix_hi;
  logic [W-1:0]   fix_lo;
  logic           accept;

`ifdef MULDIV_DIV_EN
  logic           is_div;
  logic           neg_rem;
  logic [W-1:0]   orig_a;
  logic [W:0]     rem;
  logic [W+1:0]   div_diff;
  logic [W-1:0]   quot_fix;
  logic [W-1:0]   rem_fix;

  assign accept = start_in;
`else
  // Divide opcodes are swallowed as no-ops when the divider is absent.
  assign accept = start_in && !op_in[1];
`endif

  always_comb begin
    a_mag    = (is_signed && a_reg[W-1]) ? -a_reg : a_reg;
    b_mag    = (is_signed && b_reg[W-1]) ? -b_reg : b_reg;
    mul_sum  = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? a_reg : {W{1'b0}})};
    prod_fix = neg_res ? -prod : prod;
    fix_hi   = prod_fix[2*W-1:W];
    fix_lo   = prod_fix[W-1:0];
`ifdef MULDIV_DIV_EN
    // Top bit of the W+2-bit difference is the borrow: set means restore.
    div_diff = {rem, prod[W-1]} - {2'b00, b_reg};
    quot_fix = neg_res ? -prod[W-1:0] : prod[W-1:0];
    rem_fix  = neg_rem ? -rem[W-1:0] : rem[W-1:0];
    if (is_div) begin
      if (b_reg == {W{1'b0}}) begin
        fix_hi = orig_a;
        fix_lo = {W{1'b1}};
      end else begin
        fix_hi = rem_fix;
        fix_lo = quot_fix;
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= {W{1'b0}};
      lo_q   <= {W{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= PREP;
            busy_q    <= 1'b1;
            a_reg     <= a_in;
            b_reg     <= b_in;
            is_signed <= ~op_in[0];
            neg_res   <= ~op_in[0] & (a_in[W-1] ^ b_in[W-1]);
`ifdef MULDIV_DIV_EN
            is_div    <= op_in[1];
            neg_rem   <= ~op_in[0] & a_in[W-1];
            orig_a    <= a_in;
`endif
          end else if (!start_in) begin
            if (hi_we_in) hi_q <= wdata_in;
            if (lo_we_in) lo_q <= wdata_in;
          end
        end
        PREP: begin
          a_reg <= a_mag;
          b_reg <= b_mag;
          count <= CW'(W);
          state <= ITER;
`ifdef MULDIV_DIV_EN
          rem   <= {(W+1){1'b0}};
          prod  <= {{W{1'b0}}, (is_div ? a_mag : b_mag)};
`else
          prod  <= {{W{1'b0}}, b_mag};
`endif
        end
        ITER: begin
          count <= count - 1'b1;
          if (count == CW'(1)) state <= FIX;
`ifdef MULDIV_DIV_EN
          if (is_div) begin
            prod[W-1:0] <= {prod[W-2:0], ~div_diff[W+1]};
            rem         <= div_diff[W+1] ? {rem[W-1:0], prod[W-1]} : div_diff[W:0];
          end else begin
            prod <= {mul_sum, prod[W-1:1]};
          end
`else
          prod <= {mul_sum, prod[W-1:1]};
`endif
        end
        FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_out = busy_q;
  assign done_out = done_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
// Divide expectations depend on MULDIV_DIV_EN, matching the RTL build.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start_in;
  logic [1:0]   op_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         hi_we_in;
  logic         lo_we_in;
  logic [W-1:0] wdata_in;
  logic         busy_out;
  logic         done_out;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[5];

  muldiv_unit #(.W(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start_in (start_in),
    .op_in    (op_in),
    .a_in     (a_in),
    .b_in     (b_in),
    .hi_we_in (hi_we_in),
    .lo_we_in (lo_we_in),
    .wdata_in (wdata_in),
    .busy_out (busy_out),
    .done_out (done_out),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Architectural result of one operation, from plain integer arithmetic.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sp;
    logic [63:0] up;
    int sa;
    int sb;
    case (op)
      2'd0: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        hi = sp[63:32];
        lo = sp[31:0];
      end
      2'd1: begin
        up = {32'h0, a} * {32'h0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      2'd2: begin
        if (b == 32'h0) begin
          hi = a; lo = 32'hFFFFFFFF;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          hi = 32'h0; lo = 32'h80000000;
        end else begin
          sa = a; sb = b;
          lo = sa / sb;
          hi = sa % sb;
        end
      end
      default: begin
        if (b == 32'h0) begin
          hi = a; lo = 32'hFFFFFFFF;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  // Called at a negedge; leaves the bench at the negedge of the done cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input bit poke,
                        input string tag);
    int cyc;
    int busy_cnt;
    bit held;
    start_in = 1'b1; op_in = op; a_in = a; b_in = b;
`ifndef MULDIV_DIV_EN
    if (op[1]) begin
      @(negedge clock);
      start_in = 1'b0;
      check({tag, "_noop_busy"}, busy_out, 0);
      check({tag, "_noop_done"}, done_out, 0);
      @(negedge clock);
      check({tag, "_noop_busy2"}, busy_out, 0);
      check({tag, "_noop_hi"}, hi_out, m_hi);
      check({tag, "_noop_lo"}, lo_out, m_lo);
      return;
    end
`endif
    @(negedge clock);
    start_in = 1'b0;
    cyc = 1; busy_cnt = 0; held = 1'b1;
    while (!done_out && cyc < 100) begin
      if (busy_out) busy_cnt++;
      if (hi_out !== m_hi || lo_out !== m_lo) held = 1'b0;
      hi_we_in = poke && cyc == 5;
      lo_we_in = poke && cyc == 5;
      wdata_in = 32'hABCD1234;
      if (poke && cyc == 7) begin
        start_in = 1'b1; op_in = ~op; a_in = ~a; b_in = 32'h3;
      end else begin
        start_in = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    start_in = 1'b0; hi_we_in = 1'b0; lo_we_in = 1'b0;
    check({tag, "_busy_cycles"}, busy_cnt, W + 2);
    check({tag, "_done_cycle"}, cyc, W + 3);
    check({tag, "_busy_in_done"}, busy_out, 0);
    check({tag, "_hilo_held"}, held, 1);
    check({tag, "_hi"}, hi_out, eh);
    check({tag, "_lo"}, lo_out, el);
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic mt(input bit hwe, input bit lwe, input logic [31:0] d, input string tag);
    hi_we_in = hwe; lo_we_in = lwe; wdata_in = d;
    @(negedge clock);
    hi_we_in = 1'b0; lo_we_in = 1'b0;
    if (hwe) m_hi = d;
    if (lwe) m_lo = d;
    check({tag, "_hi"}, hi_out, m_hi);
    check({tag, "_lo"}, lo_out, m_lo);
    check({tag, "_busy"}, busy_out, 0);
  endtask

  initial begin
    logic [31:0] eh;
    logic [31:0] el;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          saw_done;

    tbl[0] = '{op: 2'd1, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, hi: 32'hFFFFFFFE, lo: 32'h00000001};
    tbl[1] = '{op: 2'd0, a: 32'hFFFFFFF9, b: 32'h00000006, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFD6};
    tbl[2] = '{op: 2'd2, a: 32'hFFFFFFF9, b: 32'h00000002, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD};
    tbl[3] = '{op: 2'd2, a: 32'h80000000, b: 32'hFFFFFFFF, hi: 32'h00000000, lo: 32'h80000000};
    tbl[4] = '{op: 2'd3, a: 32'h00001234, b: 32'h00000000, hi: 32'h00001234, lo: 32'hFFFFFFFF};

    reset = 1'b0; start_in = 1'b0; op_in = 2'd0; a_in = '0; b_in = '0;
    hi_we_in = 1'b0; lo_we_in = 1'b0; wdata_in = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", busy_out, 0);
    check("reset_done", done_out, 0);
    check("reset_hi", hi_out, 0);
    check("reset_lo", lo_out, 0);
    reset = 1'b1;
    @(negedge clock);

    mt(1'b1, 1'b0, 32'hDEADBEEF, "mthi");
    mt(1'b0, 1'b1, 32'h0BADF00D, "mtlo");
    mt(1'b1, 1'b1, 32'h13572468, "mthilo");

    // Consecutive calls issue the next start in the previous done cycle.
    for (int i = 0; i < 5; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, 1'b0, $sformatf("vec%0d", i));

    @(negedge clock);
    check("mfhi_stable", hi_out, m_hi);
    check("mflo_stable", lo_out, m_lo);

    model(2'd0, 32'hFFFFFFF9, 32'h00000006, eh, el);
    run_op(2'd0, 32'hFFFFFFF9, 32'h00000006, eh, el, 1'b1, "poke_mult");

    // Reset in cycle 10 of an operation aborts it.
    start_in = 1'b1; op_in = 2'd1; a_in = 32'h12345678; b_in = 32'h9ABCDEF0;
    @(negedge clock);
    start_in = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_busy", busy_out, 0);
    check("midrst_done", done_out, 0);
    check("midrst_hi", hi_out, 0);
    check("midrst_lo", lo_out, 0);
    reset = 1'b1;
    m_hi = 32'h0; m_lo = 32'h0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done_out || busy_out) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        mt($urandom_range(0, 1) == 1, 1'b1, $urandom, $sformatf("rmt%0d", i));
      end else begin
        rop = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 4))
          0: ra = 32'h80000000;
          1: ra = 32'hFFFFFFFF;
          default: ra = $urandom;
        endcase
        case ($urandom_range(0, 5))
          0: rb = 32'h0;
          1: rb = 32'hFFFFFFFF;
          2: rb = 32'($urandom_range(1, 20));
          default: rb = $urandom;
        endcase
        model(rop, ra, rb, eh, el);
        run_op(rop, ra, rb, eh, el, 1'b0, $sformatf("rnd%0d", i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
